// File: rtl/block_host_pkg.sv
// Shared constants, field positions and state encodings for the hashing-block host.
// Imported by the host top and its serial-word reader.
package block_host_pkg;

    localparam int WORD_W = 36;

    localparam logic [2:0] OPC_ARM = 3'd7;

    // Arm/control payload layout (cmd_opcode == OPC_ARM)
    localparam int ARM_ID_MSB    = 15;
    localparam int ARM_ID_LSB    = 8;
    localparam int ARM_CYCLE_MSB = 4;
    localparam int ARM_CYCLE_LSB = 0;
    localparam int ARM_INJECT    = 5;
    localparam int ARM_SAMPLE    = 6;

    // Result word layout as it arrives LSB-first on fifo_bit
    localparam int W_DATA_MSB  = 19;
    localparam int W_DATA_LSB  = 0;
    localparam int W_ID_LO_MSB = 31;
    localparam int W_ID_LO_LSB = 20;
    localparam int W_ID_HI     = 32;
    localparam int W_MATCH     = 33;
    localparam int W_INJECT    = 34;
    localparam int W_SAMPLE    = 35;

    typedef enum logic [2:0] {
        R_IDLE,
        R_REQ,
        R_WAIT,
        R_SHIFT,
        R_DONE
    } r_state_e;

    typedef enum logic [1:0] {
        CI_IDLE,
        CI_TOGGLE,
        CI_HOLD
    } ci_state_e;

    function automatic logic [12:0] word_id(input logic [WORD_W-1:0] w);
        return {w[W_ID_HI], w[W_ID_LO_MSB:W_ID_LO_LSB]};
    endfunction

endpackage

// File: rtl/block_host_if.sv
// Host-facing command and result ports of block_host.
// master = host/consumer side, slave = block_host.
interface block_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [19:0] cmd_data;

    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_block;
    logic [19:0] res_data;
    logic [12:0] res_id;
    logic        res_match;
    logic        res_inject;
    logic        res_sample;

    modport master (
        output cmd_valid, cmd_opcode, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_block, res_data, res_id,
               res_match, res_inject, res_sample
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_data, res_ready,
        output cmd_ready, res_valid, res_block, res_data, res_id,
               res_match, res_inject, res_sample
    );
endinterface

// File: rtl/block_host_deser.sv
// One FIFO read: request cycle, dead cycle, then WORD_BITS LSB-first samples of bit_in.
// The completed word is handed over with done, or held in R_DONE while stall is high.
module block_host_deser
    import block_host_pkg::*;
#(
    parameter int WORD_BITS = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_BITS-1:0] word
);

    localparam int CNT_W = $clog2(WORD_BITS);

    r_state_e             state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_BITS-1:0] word_q, word_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        done    = 1'b0;
        case (state_q)
            R_IDLE:  if (start) state_d = R_REQ;
            R_REQ:   state_d = R_WAIT;
            R_WAIT: begin
                state_d = R_SHIFT;
                cnt_d   = '0;
            end
            R_SHIFT: begin
                word_d[cnt_q] = bit_in;
                if (cnt_q == CNT_W'(WORD_BITS - 1)) begin
                    // Hand the word over on the last sample edge when the output is free
                    if (stall) begin
                        state_d = R_DONE;
                    end else begin
                        done    = 1'b1;
                        state_d = R_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            R_DONE: begin
                if (!stall) begin
                    done    = 1'b1;
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign busy = (state_q != R_IDLE);
    assign word = word_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

endmodule

// File: rtl/block_host.sv
// Host side of the hashing blocks: toggle-strobe command serialiser plus a
// round-robin reader that collects 36-bit result words from N_BLOCKS FIFOs.
module block_host
    import block_host_pkg::*;
#(
    parameter int N_BLOCKS    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int WORD_BITS   = 36
) (
    input  logic                clk,
    input  logic                rst,
    block_host_if.slave         host,
    output logic [19:0]         command,
    output logic [2:0]          opcode,
    output logic                async_strobe,
    input  logic [N_BLOCKS-1:0] fifo_empty,
    output logic [N_BLOCKS-1:0] fifo_req,
    input  logic [N_BLOCKS-1:0] fifo_bit
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int IDX_W  = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;

    ci_state_e         ci_q, ci_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [19:0]       command_q, command_d;
    logic [2:0]        opcode_q, opcode_d;
    logic              strobe_q = 1'b0;
    logic              strobe_d;

    always_comb begin
        ci_d        = ci_q;
        cmd_ready_d = cmd_ready_q;
        hold_d      = hold_q;
        command_d   = command_q;
        opcode_d    = opcode_q;
        strobe_d    = strobe_q;
        case (ci_q)
            CI_IDLE: begin
                cmd_ready_d = 1'b1;
                if (host.cmd_valid && cmd_ready_q) begin
                    command_d   = host.cmd_data;
                    opcode_d    = host.cmd_opcode;
                    cmd_ready_d = 1'b0;
                    ci_d        = CI_TOGGLE;
                end
            end
            CI_TOGGLE: begin
                strobe_d = ~strobe_q;
                hold_d   = HOLD_W'(HOLD_CYCLES);
                ci_d     = CI_HOLD;
            end
            CI_HOLD: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q <= HOLD_W'(1)) begin
                    hold_d      = '0;
                    ci_d        = CI_IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            default: ci_d = CI_IDLE;
        endcase
    end

    // Strobe has no reset so that rst can never look like a toggle to the blocks
    always_ff @(posedge clk) begin
        strobe_q <= strobe_d;
    end

    // Reader: scan, launch a read, collect the word into the result registers
    logic [IDX_W-1:0]    ptr_q, ptr_d, sel_q, sel_d, pick, scan;
    logic                found, start, stall, busy, done;
    logic [N_BLOCKS-1:0] fifo_req_q, fifo_req_d;
    logic [WORD_BITS-1:0] word;
    logic                res_valid_q, res_valid_d;
    logic [3:0]          res_block_q, res_block_d;
    logic [19:0]         res_data_q, res_data_d;
    logic [12:0]         res_id_q, res_id_d;
    logic                res_match_q, res_match_d;
    logic                res_inject_q, res_inject_d;
    logic                res_sample_q, res_sample_d;

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        scan  = ptr_q;
        for (int i = 0; i < N_BLOCKS; i++) begin
            scan = IDX_W'((int'(ptr_q) + i) % N_BLOCKS);
            if (!found && !fifo_empty[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end

    assign start = !busy && found;
    assign stall = res_valid_q && !host.res_ready;

    block_host_deser #(.WORD_BITS(WORD_BITS)) u_deser (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bit_in (fifo_bit[sel_q]),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .word   (word)
    );

    always_comb begin
        ptr_d        = ptr_q;
        sel_d        = sel_q;
        fifo_req_d   = '0;
        res_valid_d  = res_valid_q;
        res_block_d  = res_block_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        res_match_d  = res_match_q;
        res_inject_d = res_inject_q;
        res_sample_d = res_sample_q;
        if (start) begin
            sel_d      = pick;
            ptr_d      = IDX_W'((int'(pick) + 1) % N_BLOCKS);
            fifo_req_d = N_BLOCKS'(1) << pick;
        end
        if (res_valid_q && host.res_ready) res_valid_d = 1'b0;
        if (done) begin
            res_valid_d  = 1'b1;
            res_block_d  = 4'(sel_q);
            res_data_d   = word[W_DATA_MSB:W_DATA_LSB];
            res_id_d     = word_id(word);
            res_match_d  = word[W_MATCH];
            res_inject_d = word[W_INJECT];
            res_sample_d = word[W_SAMPLE];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ci_q         <= CI_IDLE;
            cmd_ready_q  <= 1'b0;
            hold_q       <= '0;
            command_q    <= '0;
            opcode_q     <= '0;
            ptr_q        <= '0;
            sel_q        <= '0;
            fifo_req_q   <= '0;
            res_valid_q  <= 1'b0;
            res_block_q  <= '0;
            res_data_q   <= '0;
            res_id_q     <= '0;
            res_match_q  <= 1'b0;
            res_inject_q <= 1'b0;
            res_sample_q <= 1'b0;
        end else begin
            ci_q         <= ci_d;
            cmd_ready_q  <= cmd_ready_d;
            hold_q       <= hold_d;
            command_q    <= command_d;
            opcode_q     <= opcode_d;
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            fifo_req_q   <= fifo_req_d;
            res_valid_q  <= res_valid_d;
            res_block_q  <= res_block_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            res_match_q  <= res_match_d;
            res_inject_q <= res_inject_d;
            res_sample_q <= res_sample_d;
        end
    end

    assign host.cmd_ready  = cmd_ready_q;
    assign command         = command_q;
    assign opcode          = opcode_q;
    assign async_strobe    = strobe_q;
    assign fifo_req        = fifo_req_q;
    assign host.res_valid  = res_valid_q;
    assign host.res_block  = res_block_q;
    assign host.res_data   = res_data_q;
    assign host.res_id     = res_id_q;
    assign host.res_match  = res_match_q;
    assign host.res_inject = res_inject_q;
    assign host.res_sample = res_sample_q;

endmodule
